dispense_scheduler: RTL and testbench
=====================================

// Module: dispense_scheduler
// PURPOSE
//  Sequences the single shared pill actuator between the three dose slots (morning, afternoon, evening).
//  Collects timed and manual dose requests, filters them by the per-slot enable mask, and serialises them.
//  For each dose it fires one timed motor pulse, waits for pill confirmation, then cools down.
//  Sits between the time-of-day compare logic / dose setter and the GPIO actuator pin.
// PARAMETERS
//  PULSE_CYCLES    50_000_000   motor-on duration per dose (1 s @ 50 MHz)
//  CONFIRM_CYCLES  100_000_000  max wait after the pulse for pill_sense before declaring a miss
//  GAP_CYCLES      25_000_000   actuator rest time between consecutive doses
//  CNT_W           8            width of dose_count
// PORTS
//  clock         in   1      single system clock, all logic on posedge
//  resetn        in   1      synchronous, active-low reset
//  req           in   3      one-cycle dose request per slot [0]=morning [1]=afternoon [2]=evening
//  slot_en       in   3      per-slot dose enable mask; gates req only
//  manual_req    in   1      one-cycle manual dose request; bypasses slot_en
//  manual_sel    in   2      slot for manual_req; value 3 = request ignored
//  pill_sense    in   1      pill-drop sensor, already synchronous to clock
//  abort         in   1      level; cancels the current dose and all pending requests
//  clear_missed  in   1      one-cycle pulse; clears the missed flags
//  motor         out  1      actuator drive (GPIO)
//  busy          out  1      high in any state other than IDLE
//  active_slot   out  3      one-hot slot in service; 0 in IDLE
//  done          out  1      one-cycle pulse on a confirmed dose
//  missed        out  3      sticky per-slot "no pill detected" flags
//  dose_count    out  CNT_W  confirmed doses since reset; saturates at all-ones
// BEHAVIOUR
//  - Reset (resetn=0 at an edge): state=IDLE; pending, missed, dose_count, timer all 0; every output 0.
//  - Capture: pending[s] |= (req[s] & slot_en[s]) | (manual_req & manual_sel==s). A request while pending is merged.
//    A request for the slot currently in service sets pending again and is served after it.
//  - IDLE: if pending != 0, select the lowest set index (fixed priority morning>afternoon>evening),
//    clear that pending bit, load timer=PULSE_CYCLES, go to FIRE. Requests captured in the same cycle
//    are visible to arbitration one cycle later.
//  - Latency: a request sampled at edge N in IDLE raises motor after edge N+2.
//  - FIRE: motor=1 for exactly PULSE_CYCLES cycles, then load CONFIRM_CYCLES and go to WAIT.
//  - pill_sense=1 in FIRE or WAIT sets an internal confirmed flag.
//  - WAIT: motor=0. If confirmed, pulse done, increment dose_count (hold at max), load GAP_CYCLES, go to COOL.
//    If the timer expires unconfirmed, set missed[slot] and go to COOL with no done pulse and no count.
//    A FIRE that ends already confirmed spends exactly one cycle in WAIT.
//  - COOL: motor=0 for GAP_CYCLES cycles, then IDLE. The confirmed flag is cleared on entry to FIRE.
//  - active_slot holds the selected slot from FIRE through COOL.
//  - abort=1 at any edge: next state IDLE, motor=0, pending cleared, no done, no count, no missed.
//    Requests in the same cycle are dropped. abort has priority over every other input except reset.
//  - clear_missed and a miss in the same cycle: the miss is set (set wins).
//  - Timer width is $clog2(max(PULSE,CONFIRM,GAP)+1). All compares are to 1, so no wrap occurs.
// STRUCTURE
//  - Package dispenser_pkg holds:
//    - state enum {IDLE, FIRE, WAIT, COOL};
//    - SLOT_MORNING=0, SLOT_AFTERNOON=1, SLOT_EVENING=2, NUM_SLOTS=3.
//  - One sub-module, dispense_timer: a loadable down-counter with load, load_val and an expired output,
//    shared across the three timed phases.
//  - FSM, capture and arbitration live in this module.
// TESTING (bench uses PULSE=4, CONFIRM=6, GAP=3)
//  1 req=001, slot_en=111, pill_sense pulsed in FIRE -> motor high 4 cycles from edge N+2; done=1 once;
//    dose_count=1; back to IDLE after 3 cooldown cycles.
//  2 req=111 in one cycle, pill always present -> slots served 0,1,2 in order with gaps; dose_count=3.
//  3 req=010, pill_sense never -> after 4+6 cycles missed=010, no done; clear_missed -> missed=000.
//  4 req=100, slot_en=011 -> ignored, busy stays 0.
//    manual_req, manual_sel=2 -> served; manual_sel=3 -> ignored.
//  5 abort mid-FIRE with pending=110 -> motor 0 next cycle; IDLE; pending=0; counters and flags unchanged.
//  6 resetn=0 mid-WAIT -> all outputs 0 next cycle. Preload dose_count=255 via 255 doses
//    (or force) -> stays 255 on the next dose.

Source files
------------

// File: rtl/dispenser_pkg.sv
// Shared types and slot constants for the pill dispenser scheduling logic.
package dispenser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2,
    COOL = 2'd3
  } state_t;

  localparam int SLOT_MORNING   = 0;
  localparam int SLOT_AFTERNOON = 1;
  localparam int SLOT_EVENING   = 2;
  localparam int NUM_SLOTS      = 3;

  // Isolates the lowest set bit, giving morning > afternoon > evening priority.
  function automatic logic [NUM_SLOTS-1:0] lowest_onehot(input logic [NUM_SLOTS-1:0] v);
    return v & (~v + NUM_SLOTS'(1));
  endfunction

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter shared by the pulse, confirm and cooldown phases.
module dispense_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  // A phase loaded with N lasts exactly N cycles: it ends on the cycle count reads 1.
  assign expired = (count == W'(1));

endmodule

// File: rtl/dispense_scheduler.sv
// Serialises timed and manual dose requests onto the single shared pill actuator:
// pulse the motor, wait for the pill sensor, then rest before the next dose.
module dispense_scheduler
  import dispenser_pkg::*;
#(
  parameter int PULSE_CYCLES   = 50_000_000,
  parameter int CONFIRM_CYCLES = 100_000_000,
  parameter int GAP_CYCLES     = 25_000_000,
  parameter int CNT_W          = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [2:0]       req,
  input  logic [2:0]       slot_en,
  input  logic             manual_req,
  input  logic [1:0]       manual_sel,
  input  logic             pill_sense,
  input  logic             abort,
  input  logic             clear_missed,
  output logic             motor,
  output logic             busy,
  output logic [2:0]       active_slot,
  output logic             done,
  output logic [2:0]       missed,
  output logic [CNT_W-1:0] dose_count,
  output logic [1:0]       fsm_state
);

  localparam int MAX_PC  = (PULSE_CYCLES > CONFIRM_CYCLES) ? PULSE_CYCLES : CONFIRM_CYCLES;
  localparam int MAX_ALL = (MAX_PC > GAP_CYCLES) ? MAX_PC : GAP_CYCLES;
  localparam int TW      = $clog2(MAX_ALL + 1);

  // Request interface: req and manual_req are single-cycle strobes with no
  // back-pressure; a strobe is always accepted (merged into pending) unless
  // abort is high on the same edge, in which case it is dropped.

  state_t               state, state_nxt;
  logic [NUM_SLOTS-1:0] cap, cap_nxt, pending, sel, manual_vec;
  logic [NUM_SLOTS-1:0] active_q, missed_q;
  logic                 confirmed, done_q;
  logic [CNT_W-1:0]     count_q;
  logic                 take, dose_ok, dose_miss;
  logic                 t_load, t_expired;
  logic [TW-1:0]        t_val;

  dispense_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .resetn   (resetn),
    .load     (t_load),
    .load_val (t_val),
    .expired  (t_expired)
  );

  always_comb begin
    manual_vec = '0;
    if (manual_req && (manual_sel != 2'd3)) begin
      manual_vec = NUM_SLOTS'(3'b001 << manual_sel);
    end
    cap_nxt = (req & slot_en) | manual_vec;
    sel     = lowest_onehot(pending);
  end

  always_comb begin
    state_nxt = state;
    t_load    = 1'b0;
    t_val     = '0;
    take      = 1'b0;
    dose_ok   = 1'b0;
    dose_miss = 1'b0;
    case (state)
      IDLE: begin
        if (pending != '0) begin
          take      = 1'b1;
          t_load    = 1'b1;
          t_val     = TW'(PULSE_CYCLES);
          state_nxt = FIRE;
        end
      end
      FIRE: begin
        if (t_expired) begin
          t_load    = 1'b1;
          t_val     = TW'(CONFIRM_CYCLES);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (confirmed || pill_sense) begin
          dose_ok   = 1'b1;
          t_load    = 1'b1;
          t_val     = TW'(GAP_CYCLES);
          state_nxt = COOL;
        end else if (t_expired) begin
          dose_miss = 1'b1;
          t_load    = 1'b1;
          t_val     = TW'(GAP_CYCLES);
          state_nxt = COOL;
        end
      end
      COOL: begin
        if (t_expired) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides every other input and suppresses any dose outcome.
    if (abort) begin
      state_nxt = IDLE;
      t_load    = 1'b0;
      take      = 1'b0;
      dose_ok   = 1'b0;
      dose_miss = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      cap       <= '0;
      pending   <= '0;
      active_q  <= '0;
      confirmed <= 1'b0;
      done_q    <= 1'b0;
      missed_q  <= '0;
      count_q   <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= dose_ok;
      if (abort) begin
        cap     <= '0;
        pending <= '0;
      end else begin
        // The capture stage makes new requests visible to arbitration one cycle later.
        cap     <= cap_nxt;
        pending <= (pending & ~(take ? sel : '0)) | cap;
      end
      if (state_nxt == IDLE) begin
        active_q <= '0;
      end else if (take) begin
        active_q <= sel;
      end
      if (take) begin
        confirmed <= 1'b0;
      end else if (((state == FIRE) || (state == WAIT)) && pill_sense) begin
        confirmed <= 1'b1;
      end
      if (dose_ok && (count_q != '1)) begin
        count_q <= count_q + CNT_W'(1);
      end
      if (!abort) begin
        // A miss on the same edge as clear_missed still sets its flag.
        missed_q <= (clear_missed ? '0 : missed_q) | (dose_miss ? active_q : '0);
      end
    end
  end

  assign motor       = (state == FIRE);
  assign busy        = (state != IDLE);
  assign active_slot = active_q;
  assign done        = done_q;
  assign missed      = missed_q;
  assign dose_count  = count_q;
  assign fsm_state   = state;

endmodule

// File: tb/tb_dispense_scheduler.sv
// Directed bench for dispense_scheduler with short phase lengths (pulse 4, confirm 6, gap 3).
module tb_dispense_scheduler;
  import dispenser_pkg::*;

  localparam int PULSE   = 4;
  localparam int CONFIRM = 6;
  localparam int GAP     = 3;
  localparam int CNT_W   = 8;

  logic             clock = 1'b0;
  logic             resetn;
  logic [2:0]       req, slot_en;
  logic             manual_req;
  logic [1:0]       manual_sel;
  logic             pill_sense, abort, clear_missed;
  logic             motor, busy, done;
  logic [2:0]       active_slot, missed;
  logic [CNT_W-1:0] dose_count;
  logic [1:0]       fsm_state;

  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0] exp_count;
  logic [2:0] exp_q[$];

  always #5 clock = ~clock;

  dispense_scheduler #(
    .PULSE_CYCLES   (PULSE),
    .CONFIRM_CYCLES (CONFIRM),
    .GAP_CYCLES     (GAP),
    .CNT_W          (CNT_W)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .req          (req),
    .slot_en      (slot_en),
    .manual_req   (manual_req),
    .manual_sel   (manual_sel),
    .pill_sense   (pill_sense),
    .abort        (abort),
    .clear_missed (clear_missed),
    .motor        (motor),
    .busy         (busy),
    .active_slot  (active_slot),
    .done         (done),
    .missed       (missed),
    .dose_count   (dose_count),
    .fsm_state    (fsm_state)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input int budget, output int dones);
    int n;
    dones = 0;
    n = 0;
    while (busy && (n < budget)) begin
      step();
      n++;
      if (done) dones++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req = 3'b111; manual_req = 1'b1; manual_sel = 2'd0;
    step(); step();
    req = 3'b000; manual_req = 1'b0;
    checks++;
    if ({motor, busy, active_slot, done, missed, dose_count} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", {motor, busy, active_slot, done, missed, dose_count});
    end
    checks++;
    if (fsm_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, required %0d", fsm_state, IDLE);
    end
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_dose: busy=%b at cycle %0d, required 0", busy, k);
      end
    end
  endtask

  task automatic test_single_dose();
    logic [5:0] got, want;
    slot_en = 3'b111;
    req = 3'b001;
    for (int k = 0; k <= 10; k++) begin
      pill_sense = (k == 3);
      step();
      if (k == 0) req = 3'b000;
      want = {(k >= 2 && k <= 5), (k >= 2 && k <= 9),
              ((k >= 2 && k <= 9) ? 3'b001 : 3'b000), (k == 7)};
      got = {motor, busy, active_slot, done};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL single_dose k=%0d: {motor,busy,slot,done} got %b, required %b", k, got, want);
      end
    end
    pill_sense = 1'b0;
    exp_count = 8'd1;
    checks++;
    if (dose_count !== exp_count) begin
      errors++;
      $display("FAIL single_count: got %0d, required %0d", dose_count, exp_count);
    end
  endtask

  task automatic test_priority();
    int motor_cycles, busy_cycles;
    logic [2:0] got_q[$];
    motor_cycles = 0;
    busy_cycles = 0;
    exp_q = {3'b001, 3'b010, 3'b100};
    pill_sense = 1'b1;
    req = 3'b111;
    step();
    req = 3'b000;
    for (int k = 0; k < 60; k++) begin
      step();
      if (motor) motor_cycles++;
      if (busy) busy_cycles++;
      if (done) got_q.push_back(active_slot);
    end
    pill_sense = 1'b0;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL priority_dones: got %0d, required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL priority_order[%0d]: got %b, required %b", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (motor_cycles != 3 * PULSE) begin
      errors++;
      $display("FAIL priority_motor_cycles: got %0d, required %0d", motor_cycles, 3 * PULSE);
    end
    // Per dose: FIRE 4 + WAIT 1 + COOL 3; doses separated by one IDLE cycle.
    checks++;
    if (busy_cycles != 24) begin
      errors++;
      $display("FAIL priority_busy_cycles: got %0d, required 24", busy_cycles);
    end
    exp_count = 8'd4;
    checks++;
    if (dose_count !== exp_count) begin
      errors++;
      $display("FAIL priority_count: got %0d, required %0d", dose_count, exp_count);
    end
  endtask

  task automatic test_missed();
    int dones;
    dones = 0;
    req = 3'b010;
    step();
    req = 3'b000;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (done) dones++;
      if (k == 11) begin
        checks++;
        if (missed !== 3'b000) begin
          errors++;
          $display("FAIL missed_early: got %b, required 000", missed);
        end
      end
    end
    checks++;
    if (missed !== 3'b010) begin
      errors++;
      $display("FAIL missed_set: got %b, required 010", missed);
    end
    step_n(4);
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL missed_no_done: got %0d done pulses, required 0", dones);
    end
    checks++;
    if ({busy, dose_count} !== {1'b0, exp_count}) begin
      errors++;
      $display("FAIL missed_idle_count: busy=%b count=%0d, required 0 and %0d", busy, dose_count, exp_count);
    end
    clear_missed = 1'b1;
    step();
    clear_missed = 1'b0;
    checks++;
    if (missed !== 3'b000) begin
      errors++;
      $display("FAIL missed_clear: got %b, required 000", missed);
    end
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_mask_manual();
    int dones;
    slot_en = 3'b011;
    req = 3'b100;
    step();
    req = 3'b000;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL mask_ignored: busy=%b at cycle %0d, required 0", busy, k);
      end
    end
    pill_sense = 1'b1;
    manual_req = 1'b1; manual_sel = 2'd2;
    step();
    manual_req = 1'b0;
    step(); step();
    checks++;
    if ({motor, active_slot} !== 4'b1100) begin
      errors++;
      $display("FAIL manual_fire: {motor,slot} got %b, required 1100", {motor, active_slot});
    end
    wait_idle(30, dones);
    pill_sense = 1'b0;
    exp_count = exp_count + 8'd1;
    checks++;
    if (dones != 1 || dose_count !== exp_count) begin
      errors++;
      $display("FAIL manual_done: dones=%0d count=%0d, required 1 and %0d", dones, dose_count, exp_count);
    end
    manual_req = 1'b1; manual_sel = 2'd3;
    step();
    manual_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL manual_sel3: busy=%b at cycle %0d, required 0", busy, k);
      end
    end
    slot_en = 3'b111;
  endtask

  task automatic test_abort();
    req = 3'b001;
    step();
    req = 3'b110;
    step();
    req = 3'b000;
    step(); step();
    checks++;
    if ({motor, active_slot} !== 4'b1001) begin
      errors++;
      $display("FAIL abort_pre_fire: {motor,slot} got %b, required 1001", {motor, active_slot});
    end
    abort = 1'b1;
    req = 3'b011;
    step();
    abort = 1'b0;
    req = 3'b000;
    checks++;
    if ({motor, busy, active_slot, done} !== 6'd0) begin
      errors++;
      $display("FAIL abort_outputs: {motor,busy,slot,done} got %b, required 000000", {motor, busy, active_slot, done});
    end
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_pending_cleared: busy=%b at cycle %0d, required 0", busy, k);
      end
    end
    checks++;
    if ({dose_count, missed} !== {exp_count, 3'b000}) begin
      errors++;
      $display("FAIL abort_counters: count=%0d missed=%b, required %0d and 000", dose_count, missed, exp_count);
    end
  endtask

  task automatic test_reset_wait();
    req = 3'b001;
    step();
    req = 3'b000;
    step_n(7);
    checks++;
    if (fsm_state !== WAIT) begin
      errors++;
      $display("FAIL reset_wait_state: got %0d, required %0d", fsm_state, WAIT);
    end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    exp_count = '0;
    checks++;
    if ({motor, busy, active_slot, done, missed, dose_count} !== 17'd0) begin
      errors++;
      $display("FAIL reset_wait_outputs: got %h, required 0", {motor, busy, active_slot, done, missed, dose_count});
    end
  endtask

  task automatic test_saturation();
    int dones, total;
    total = 0;
    pill_sense = 1'b1;
    for (int i = 0; i < 255; i++) begin
      req = 3'b001;
      step();
      req = 3'b000;
      step(); step();
      wait_idle(40, dones);
      total += dones;
    end
    exp_count = 8'd255;
    checks++;
    if (total != 255 || dose_count !== exp_count) begin
      errors++;
      $display("FAIL sat_preload: dones=%0d count=%0d, required 255 and 255", total, dose_count);
    end
    req = 3'b001;
    step();
    req = 3'b000;
    step(); step();
    wait_idle(40, dones);
    pill_sense = 1'b0;
    checks++;
    if (dones != 1 || dose_count !== exp_count) begin
      errors++;
      $display("FAIL sat_hold: dones=%0d count=%0d, required 1 and 255", dones, dose_count);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    req = 3'b000; slot_en = 3'b111;
    manual_req = 1'b0; manual_sel = 2'd0;
    pill_sense = 1'b0; abort = 1'b0; clear_missed = 1'b0;
    exp_count = '0;
    test_reset();
    test_single_dose();
    test_priority();
    test_missed();
    test_mask_manual();
    test_abort();
    test_reset_wait();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
